// File: rtl/lock_attempt_guard.sv
// rtl/lock_attempt_guard.sv - brute-force guard between the ENTER button and the lock FSM
module lock_attempt_guard #(
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 50_000_000,
    parameter int CNT_W          = 26,
    parameter int SYNC_STAGES    = 2
) (
    input  logic             clk,
    input  logic             RESETN,
    input  logic             ENTER,
    input  logic             result_valid,
    input  logic             result_match,
    output logic             enter_req,
    output logic             lockout,
    output logic [3:0]       fail_count,
    output logic [CNT_W-1:0] lockout_remaining,
    output logic [3:0]       lockout_events
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_LOCKOUT  = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_t;

    localparam logic [3:0]       LAST_FAIL = 4'(MAX_FAILS - 1);
    localparam logic [CNT_W-1:0] LOAD      = CNT_W'(LOCKOUT_CYCLES);

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] sync;
    logic                   enter_s;
    logic                   trip;

    always_ff @(posedge clk or posedge RESETN) begin
        if (RESETN) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], ENTER};
        end
    end

    assign enter_s = sync[SYNC_STAGES-1];

    // A failure that reaches the limit overrides every other transition.
    assign trip = result_valid && !result_match && (fail_count == LAST_FAIL)
                  && (state != ST_LOCKOUT);

    always_ff @(posedge clk or posedge RESETN) begin
        if (RESETN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (trip) begin
            state_next = ST_LOCKOUT;
        end else begin
            case (state)
                ST_IDLE:     if (enter_s)  state_next = ST_PRESSED;
                ST_PRESSED:  if (!enter_s) state_next = ST_IDLE;
                ST_LOCKOUT: begin
                    if (lockout_remaining == CNT_W'(1))
                        state_next = enter_s ? ST_COOLDOWN : ST_IDLE;
                end
                ST_COOLDOWN: if (!enter_s) state_next = ST_IDLE;
                default:     state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        enter_req = (state == ST_PRESSED);
        lockout   = (state == ST_LOCKOUT);
    end

    always_ff @(posedge clk or posedge RESETN) begin
        if (RESETN) begin
            fail_count        <= 4'd0;
            lockout_remaining <= '0;
            lockout_events    <= 4'd0;
        end else begin
            if (trip) begin
                fail_count        <= 4'd0;
                lockout_remaining <= LOAD;
                if (lockout_events != 4'd15)
                    lockout_events <= lockout_events + 4'd1;
            end else if (state == ST_LOCKOUT) begin
                lockout_remaining <= lockout_remaining - CNT_W'(1);
            end else if (result_valid) begin
                fail_count <= result_match ? 4'd0 : fail_count + 4'd1;
            end
        end
    end

endmodule

// File: doc/lock_attempt_guard.md
# lock_attempt_guard

Brute-force guard for the combination lock. Sits between the active-high ENTER button level and the lock FSM. It synchronizes ENTER and forwards it as `enter_req`. It counts consecutive failed unlock attempts reported back by the lock datapath. After `MAX_FAILS` failures it enters a timed lockout, during which ENTER is blocked and attempt results are ignored.

## Interface
Parameters:
- `MAX_FAILS`, default 3: consecutive failures that trigger lockout; legal range 1..15.
- `LOCKOUT_CYCLES`, default 50_000_000: lockout duration in clk cycles (1 s at 50 MHz); must be ≥ 1.
- `CNT_W`, default 26: lockout counter width; must hold `LOCKOUT_CYCLES`.
- `SYNC_STAGES`, default 2: ENTER synchronizer depth; must be ≥ 2.

Ports:
- `clk`  in  1  single clock; all state on posedge.
- `RESETN`  in  1  asynchronous, active-high reset (despite the name); clears all state.
- `ENTER`  in  1  raw button level, 1 = pressed, asynchronous to clk.
- `result_valid`  in  1  one-cycle pulse: lock datapath finished evaluating an attempt.
- `result_match`  in  1  qualified by `result_valid`; 1 = attempt equals password.
- `enter_req`  out  1  filtered ENTER level to lock FSM; registered.
- `lockout`  out  1  1 while lockout timer runs.
- `fail_count`  out  4  consecutive failures since last match or lockout.
- `lockout_remaining`  out  CNT_W  cycles left in lockout; 0 outside lockout.
- `lockout_events`  out  4  number of lockouts since reset, saturating at 15.

## Operation
- Synchronizer: ENTER passes through `SYNC_STAGES` flops, all reset to 0. `enter_s` is the last stage.
- States: IDLE, PRESSED, LOCKOUT, COOLDOWN. Reset state is IDLE.
- Moore outputs:
  - `enter_req` = (state == PRESSED).
  - `lockout` = (state == LOCKOUT).
- Transitions, in priority order:
  1. Any state except LOCKOUT: `result_valid` && !`result_match` && `fail_count` == MAX_FAILS-1 → LOCKOUT.
     - Load `lockout_remaining` = LOCKOUT_CYCLES.
     - Set `fail_count` = 0.
     - `lockout_events` += 1, saturating.
  2. IDLE: `enter_s` = 1 → PRESSED.
  3. PRESSED: `enter_s` = 0 → IDLE.
  4. LOCKOUT: decrement `lockout_remaining` each cycle. When it equals 1 (next value 0), go to COOLDOWN if `enter_s` = 1, else IDLE.
  5. COOLDOWN: `enter_s` = 0 → IDLE.
     - A button held through lockout never produces `enter_req`; a fresh press is required.
- Failure counting, outside LOCKOUT only:
  - `result_valid` && `result_match`: `fail_count` ← 0.
  - `result_valid` && !`result_match`: `fail_count` ← `fail_count`+1, unless rule 1 fires.
- In LOCKOUT, `result_valid` is ignored entirely: no count change, no state change.
- Simultaneous events:
  - Lockout-triggering failure in the same cycle as `enter_s` rising in IDLE: LOCKOUT wins.
  - Lockout-triggering failure while in PRESSED: `enter_req` drops the next cycle.
- `fail_count` never exceeds MAX_FAILS-1 when observed.
- MAX_FAILS = 1: every failure locks out.
- Reset asserted at any time, including mid-lockout: all outputs 0, state IDLE, synchronizer cleared.

## Timing
- Reset values: `enter_req`=0, `lockout`=0, `fail_count`=0, `lockout_remaining`=0, `lockout_events`=0.
- ENTER rise or fall → `enter_req` change: SYNC_STAGES+1 cycles, when no lockout intervenes.
- `result_valid` at edge N → `fail_count` and `lockout` updated after edge N, visible in cycle N+1.
- `lockout` is high for exactly LOCKOUT_CYCLES cycles.
  - `lockout_remaining` reads LOCKOUT_CYCLES, LOCKOUT_CYCLES-1, …, 1, then 0 once `lockout` falls.
- First possible `enter_req` after lockout, with ENTER released: SYNC_STAGES+1 cycles after a new press.
- No combinational path from any input to any output.

## Test plan
All scenarios use MAX_FAILS=3, LOCKOUT_CYCLES=8, SYNC_STAGES=2.

1. Reset, then ENTER=1 at cycle 0 → `enter_req`=1 from cycle 3. ENTER=0 at cycle 10 → `enter_req`=0 from cycle 13. All other outputs stay 0.
2. Two fails then a match (`result_valid` pulses, `result_match`=0,0,1) → `fail_count` reads 1, 2, 0; `lockout` stays 0.
3. Three fails → `lockout`=1 for exactly 8 cycles; `lockout_remaining` reads 8..1 then 0; `fail_count`=0; `lockout_events`=1. A fail pulse injected mid-lockout causes no change.
4. ENTER held from before lockout through its end → `enter_req` stays 0. Release, then press again → `enter_req`=1 three cycles after the new press.
5. Third fail in the same cycle as `enter_s` rises in IDLE → next state LOCKOUT, `enter_req` never asserts. Third fail while `enter_req`=1 → `enter_req`=0 next cycle.
6. RESETN pulsed at `lockout_remaining`=5 → all outputs 0 immediately. 16 lockouts → `lockout_events` saturates at 15.
